// File: rtl/controle_senha_if.sv
// Keypad/lock signal bundle for controle_senha.
// master: keypad decoder side (drives the entry buffer and strobe).
// slave : password controller side (drives lock, beeper and status).
interface controle_senha_if;
    logic [79:0] digitos_value;
    logic        digitos_valid;
    logic        teclado_en;
    logic        tranca;
    logic        bip;
    logic        bloqueado;
    logic        prog_ok;
    logic [1:0]  tentativas;

    modport master (
        output digitos_value, digitos_valid,
        input  teclado_en, tranca, bip, bloqueado, prog_ok, tentativas
    );

    modport slave (
        input  digitos_value, digitos_valid,
        output teclado_en, tranca, bip, bloqueado, prog_ok, tentativas
    );
endinterface

// File: rtl/controle_senha.sv
// Keypad password lock controller: checks entries against a stored
// password, opens the lock, beeps on errors, locks out after repeated
// failures and allows reprogramming after a successful verification.
//
// state         | meaning
// --------------+--------------------------------------------------
// INIT          | one cycle after reset, keypad held disabled
// IDLE          | listening for an entry, all-B or all-E event
// ABERTO        | lock released for T_ABERTO cycles
// ERRO          | error beep for T_BIP cycles
// BLOQUEIO      | lockout (beep + indicator) for T_BLOQ cycles
// PROG_VERIFICA | listening for the current password before reprogram
// PROG_NOVA     | listening for the new password
module controle_senha #(
    parameter logic [79:0] SENHA_PADRAO = 80'hFFFF_FFFF_FFFF_FFFF_1234,
    parameter int          MAX_TENT     = 3,
    parameter int          T_ABERTO     = 5000,
    parameter int          T_BIP        = 500,
    parameter int          T_BLOQ       = 30000
) (
    input  logic              clk,
    input  logic              rst,
    controle_senha_if.slave   bus
);

    localparam int T_MAX_AB = (T_ABERTO > T_BIP) ? T_ABERTO : T_BIP;
    localparam int T_MAX    = (T_MAX_AB > T_BLOQ) ? T_MAX_AB : T_BLOQ;
    localparam int TW       = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);

    localparam logic [TW-1:0] FIM_ABERTO = TW'(T_ABERTO - 1);
    localparam logic [TW-1:0] FIM_BIP    = TW'(T_BIP - 1);
    localparam logic [TW-1:0] FIM_BLOQ   = TW'(T_BLOQ - 1);
    localparam logic [1:0]    MAX_T      = 2'(MAX_TENT);

    localparam logic [79:0] TUDO_E = {20{4'hE}};
    localparam logic [79:0] TUDO_B = {20{4'hB}};

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ABERTO,
        ERRO,
        BLOQUEIO,
        PROG_VERIFICA,
        PROG_NOVA
    } estado_t;

    estado_t         state_q, state_d;
    logic [79:0]     senha_q, senha_d;
    logic [1:0]      tent_q, tent_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            prog_ok_q, prog_ok_d;

    logic            eh_timeout, eh_hash, bem_formada, confere;
    logic [3:0]      nib;
    logic [4:0]      n_dig;
    logic            em_digitos, cauda_ok;
    logic [1:0]      tent_inc;

    assign eh_timeout = (bus.digitos_value == TUDO_E);
    assign eh_hash    = (bus.digitos_value == TUDO_B);

    // Well-formed: a run of decimal digits from nibble 0 upward, 4..12 long,
    // with every nibble above the run equal to F.
    always_comb begin
        nib        = '0;
        n_dig      = '0;
        em_digitos = 1'b1;
        cauda_ok   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            nib = bus.digitos_value[4*i +: 4];
            if (em_digitos && (nib <= 4'd9)) begin
                n_dig = n_dig + 5'd1;
            end else begin
                em_digitos = 1'b0;
                if (nib != 4'hF) cauda_ok = 1'b0;
            end
        end
        bem_formada = cauda_ok && (n_dig >= 5'd4) && (n_dig <= 5'd12);
    end

    assign confere  = bem_formada && (bus.digitos_value == senha_q);
    assign tent_inc = (tent_q == MAX_T) ? tent_q : tent_q + 2'd1;

    // Next-state, password, failure count and shared timer.
    // The timer is zero in every non-timed state, so it starts at 0 on entry.
    always_comb begin
        state_d   = state_q;
        senha_d   = senha_q;
        tent_d    = tent_q;
        timer_d   = '0;
        prog_ok_d = 1'b0;
        case (state_q)
            INIT: state_d = IDLE;
            IDLE: begin
                if (bus.digitos_valid && !eh_timeout) begin
                    if (eh_hash) begin
                        state_d = PROG_VERIFICA;
                    end else if (confere) begin
                        state_d = ABERTO;
                        tent_d  = 2'd0;
                    end else begin
                        tent_d  = tent_inc;
                        state_d = (tent_inc == MAX_T) ? BLOQUEIO : ERRO;
                    end
                end
            end
            ABERTO: begin
                if (timer_q == FIM_ABERTO) state_d = IDLE;
                else                       timer_d = timer_q + 1'b1;
            end
            ERRO: begin
                if (timer_q == FIM_BIP) state_d = IDLE;
                else                    timer_d = timer_q + 1'b1;
            end
            BLOQUEIO: begin
                if (timer_q == FIM_BLOQ) begin
                    state_d = IDLE;
                    tent_d  = 2'd0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PROG_VERIFICA: begin
                if (bus.digitos_valid) begin
                    if (eh_timeout || eh_hash) begin
                        state_d = IDLE;
                    end else if (confere) begin
                        state_d = PROG_NOVA;
                    end else begin
                        tent_d  = tent_inc;
                        state_d = (tent_inc == MAX_T) ? BLOQUEIO : ERRO;
                    end
                end
            end
            PROG_NOVA: begin
                if (bus.digitos_valid) begin
                    if (eh_timeout || eh_hash) begin
                        state_d = IDLE;
                    end else if (bem_formada) begin
                        senha_d   = bus.digitos_value;
                        prog_ok_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = ERRO;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State and datapath registers with asynchronous reset to defaults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            senha_q   <= SENHA_PADRAO;
            tent_q    <= 2'd0;
            timer_q   <= '0;
            prog_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            senha_q   <= senha_d;
            tent_q    <= tent_d;
            timer_q   <= timer_d;
            prog_ok_q <= prog_ok_d;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        bus.teclado_en = 1'b0;
        bus.tranca     = 1'b0;
        bus.bip        = 1'b0;
        bus.bloqueado  = 1'b0;
        case (state_q)
            IDLE, PROG_VERIFICA, PROG_NOVA: bus.teclado_en = 1'b1;
            ABERTO:   bus.tranca = 1'b1;
            ERRO:     bus.bip    = 1'b1;
            BLOQUEIO: begin
                bus.bip       = 1'b1;
                bus.bloqueado = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.prog_ok    = prog_ok_q;
    assign bus.tentativas = tent_q;

endmodule

// File: tb/tb_controle_senha.sv
// Directed bench for controle_senha with short timer parameters.
module tb_controle_senha;

    localparam logic [79:0] P1234   = 80'hFFFF_FFFF_FFFF_FFFF_1234;
    localparam logic [79:0] P9999   = 80'hFFFF_FFFF_FFFF_FFFF_9999;
    localparam logic [79:0] P567890 = 80'hFFFF_FFFF_FFFF_FF56_7890;
    localparam logic [79:0] P123    = 80'hFFFF_FFFF_FFFF_FFFF_F123;
    localparam logic [79:0] P1A34   = 80'hFFFF_FFFF_FFFF_FFFF_1A34;
    localparam logic [79:0] P12DIG  = 80'hFFFF_FFFF_1234_5678_9012;
    localparam logic [79:0] PE      = {20{4'hE}};
    localparam logic [79:0] PB      = {20{4'hB}};

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    controle_senha_if bus ();

    controle_senha #(
        .SENHA_PADRAO (P1234),
        .MAX_TENT     (3),
        .T_ABERTO     (10),
        .T_BIP        (4),
        .T_BLOQ       (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [79:0] v);
        @(negedge clk);
        bus.digitos_value = v;
        bus.digitos_valid = 1'b1;
        @(negedge clk);
        bus.digitos_valid = 1'b0;
    endtask

    // Counts consecutive cycles a status output stays high (0 tranca, 1 bip,
    // 2 bloqueado); optionally fires a stray 9999 event three cycles in.
    task automatic conta(input int sel, input bit injeta, output int n, output bit en_visto);
        logic s;
        n = 0;
        en_visto = 1'b0;
        for (int k = 0; k < 100; k++) begin
            case (sel)
                0:       s = bus.tranca;
                1:       s = bus.bip;
                default: s = bus.bloqueado;
            endcase
            if (!s) break;
            n++;
            if (bus.teclado_en) en_visto = 1'b1;
            if (injeta && n == 3) begin
                bus.digitos_value = P9999;
                bus.digitos_valid = 1'b1;
            end else begin
                bus.digitos_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.digitos_valid = 1'b0;
    endtask

    task automatic reset_pulso();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_teclado", bus.teclado_en, 0);
        chk("rst_async_tranca", bus.tranca, 0);
        chk("rst_async_bip", bus.bip, 0);
        chk("rst_async_bloq", bus.bloqueado, 0);
        chk("rst_async_prog_ok", bus.prog_ok, 0);
        chk("rst_async_tent", bus.tentativas, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_release_teclado", bus.teclado_en, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit en;

        rst = 1'b0;
        bus.digitos_value = '0;
        bus.digitos_valid = 1'b0;
        #2 rst = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_teclado", bus.teclado_en, 0);
        chk("reset_tranca", bus.tranca, 0);
        chk("reset_bip", bus.bip, 0);
        chk("reset_bloq", bus.bloqueado, 0);
        chk("reset_prog_ok", bus.prog_ok, 0);
        chk("reset_tent", bus.tentativas, 0);
        rst = 1'b0;
        #1;
        chk("init_teclado_c1", bus.teclado_en, 0);
        @(negedge clk);
        chk("init_teclado_c2", bus.teclado_en, 1);

        // Correct entry, with a stray event during ABERTO
        send(P1234);
        conta(0, 1'b1, n, en);
        chk("aberto_ciclos", n, 10);
        chk("aberto_teclado_baixo", en, 0);
        chk("aberto_tent", bus.tentativas, 0);
        chk("aberto_volta_idle", bus.teclado_en, 1);

        // Lockout after three failures; stray events in ERRO and BLOQUEIO
        send(P9999);
        conta(1, 1'b1, n, en);
        chk("erro1_bip", n, 4);
        chk("erro1_tent", bus.tentativas, 1);
        send(P9999);
        conta(1, 1'b0, n, en);
        chk("erro2_bip", n, 4);
        chk("erro2_tent", bus.tentativas, 2);
        send(P9999);
        chk("bloq_bip", bus.bip, 1);
        chk("bloq_tent", bus.tentativas, 3);
        conta(2, 1'b1, n, en);
        chk("bloq_ciclos", n, 20);
        chk("bloq_saida_tent", bus.tentativas, 0);
        chk("bloq_saida_bip", bus.bip, 0);

        // Boundaries: all-E, 3 digits, non-digit nibble
        send(PE);
        chk("timeout_idle_teclado", bus.teclado_en, 1);
        chk("timeout_idle_tent", bus.tentativas, 0);
        chk("timeout_idle_bip", bus.bip, 0);
        send(P123);
        conta(1, 1'b0, n, en);
        chk("tres_dig_bip", n, 4);
        chk("tres_dig_tent", bus.tentativas, 1);
        send(PE);
        chk("timeout_tent_mantido", bus.tentativas, 1);
        send(P1A34);
        conta(1, 1'b0, n, en);
        chk("nib_a_bip", n, 4);
        chk("nib_a_tent", bus.tentativas, 2);
        send(P1234);
        conta(0, 1'b0, n, en);
        chk("acerto_limpa_ciclos", n, 10);
        chk("acerto_limpa_tent", bus.tentativas, 0);

        // Reprogramming
        send(PB);
        chk("prog_verif_teclado", bus.teclado_en, 1);
        send(P1234);
        chk("prog_nova_teclado", bus.teclado_en, 1);
        chk("prog_nova_sem_pulso", bus.prog_ok, 0);
        send(P567890);
        chk("prog_ok_pulso", bus.prog_ok, 1);
        @(negedge clk);
        chk("prog_ok_um_ciclo", bus.prog_ok, 0);
        send(P1234);
        conta(1, 1'b0, n, en);
        chk("senha_antiga_bip", n, 4);
        chk("senha_antiga_tent", bus.tentativas, 1);
        send(P567890);
        conta(0, 1'b0, n, en);
        chk("senha_nova_abre", n, 10);
        chk("senha_nova_tent", bus.tentativas, 0);

        // 12-digit password
        send(PB);
        send(P567890);
        send(P12DIG);
        chk("prog12_ok", bus.prog_ok, 1);
        send(P12DIG);
        conta(0, 1'b0, n, en);
        chk("doze_dig_abre", n, 10);

        // Reset while in PROG_NOVA restores the default password
        send(PB);
        send(P12DIG);
        chk("pre_rst_prog_nova", bus.teclado_en, 1);
        reset_pulso();
        send(P1234);
        conta(0, 1'b0, n, en);
        chk("pos_rst_nova_abre", n, 10);

        // Reset during lockout
        send(P9999);
        conta(1, 1'b0, n, en);
        send(P9999);
        conta(1, 1'b0, n, en);
        send(P9999);
        repeat (5) @(negedge clk);
        chk("pre_rst_bloq", bus.bloqueado, 1);
        reset_pulso();
        send(P1234);
        conta(0, 1'b0, n, en);
        chk("pos_rst_bloq_abre", n, 10);
        chk("pos_rst_bloq_tent", bus.tentativas, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
